// File: rtl/sm_controller.sv
// sm_controller: add/shift sequencer for the N_BITS sequential multiplier datapath.
//
// Ports:
//   clk_i      rising-edge clock
//   rst_ni     asynchronous active-low reset
//   start_i    multiply request, sampled only while idle
//   mr_i       multiplier register read back from the datapath
//   mdld_o     load multiplicand register
//   mrld_o     load multiplier register
//   rsclear_o  clear running sum
//   rsload_o   add multiplicand into the running sum upper half
//   rsshr_o    shift running sum right one bit
//   busy_o     high in every non-idle state
//   done_o     one-cycle pulse, product valid on the datapath
//   bitidx_o   multiplier bit currently being processed
module sm_controller #(
    parameter int N_BITS    = 4,
    parameter bit SKIP_ZERO = 1'b0,
    localparam int IW       = (N_BITS > 1) ? $clog2(N_BITS) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [N_BITS-1:0] mr_i,
    output logic              mdld_o,
    output logic              mrld_o,
    output logic              rsclear_o,
    output logic              rsload_o,
    output logic              rsshr_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [IW-1:0]     bitidx_o
);
    typedef enum logic [2:0] {IDLE, LOAD, ADD, SHIFT, DONE} state_e;
    state_e        state_q;
    logic [IW-1:0] bitidx_q;
    logic [IW-1:0] idx_inc;
    logic          ld_q;
    logic          rsshr_q;
    logic          busy_q;
    logic          done_q;
    assign idx_inc = bitidx_q + IW'(1);
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            bitidx_q <= '0;
            ld_q     <= 1'b0;
            rsshr_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    state_q  <= LOAD;
                    ld_q     <= 1'b1;
                    busy_q   <= 1'b1;
                    bitidx_q <= '0;
                end
                LOAD: begin
                    state_q <= ADD;
                    ld_q    <= 1'b0;
                end
                ADD: begin
                    state_q <= SHIFT;
                    rsshr_q <= 1'b1;
                end
                SHIFT: if (bitidx_q == IW'(N_BITS - 1)) begin
                    state_q <= DONE;
                    rsshr_q <= 1'b0;
                    done_q  <= 1'b1;
                end else begin
                    bitidx_q <= idx_inc;
                    // a zero next bit in skip mode needs no add: keep shifting
                    if (!(SKIP_ZERO && !mr_i[idx_inc])) begin
                        state_q <= ADD;
                        rsshr_q <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    // mr is only valid after the LOAD edge, so the add strobe is decoded
    // from the registered ADD state rather than registered itself
    assign rsload_o  = (state_q == ADD) && mr_i[bitidx_q];
    assign rsshr_o   = rsshr_q;
    assign mdld_o    = ld_q;
    assign mrld_o    = ld_q;
    assign rsclear_o = ld_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign bitidx_o  = bitidx_q;
endmodule

// File: tb/tb_sm_controller.sv
// tb_sm_controller: checks both latency modes of sm_controller against a datapath model and expected strobe timelines.
module tb_sm_controller;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start [2];
    logic [3:0] md_in = '0;
    logic [3:0] mr_in = '0;
    logic       mdld [2];
    logic       mrld [2];
    logic       rsclear [2];
    logic       rsload [2];
    logic       rsshr [2];
    logic       busy [2];
    logic       done [2];
    logic [1:0] bidx [2];
    logic [8:0] sum [2];
    logic [3:0] mdr [2];
    logic [3:0] mrr [2];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    sm_controller #(.N_BITS(4), .SKIP_ZERO(1'b0)) u0 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start[0]), .mr_i(mrr[0]),
        .mdld_o(mdld[0]), .mrld_o(mrld[0]), .rsclear_o(rsclear[0]), .rsload_o(rsload[0]),
        .rsshr_o(rsshr[0]), .busy_o(busy[0]), .done_o(done[0]), .bitidx_o(bidx[0])
    );
    sm_controller #(.N_BITS(4), .SKIP_ZERO(1'b1)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start[1]), .mr_i(mrr[1]),
        .mdld_o(mdld[1]), .mrld_o(mrld[1]), .rsclear_o(rsclear[1]), .rsload_o(rsload[1]),
        .rsshr_o(rsshr[1]), .busy_o(busy[1]), .done_o(done[1]), .bitidx_o(bidx[1])
    );

    // behavioural datapath: 9-bit running sum keeps the add carry until the shift
    for (genvar g = 0; g < 2; g++) begin : dp
        initial begin
            sum[g] = '0;
            mdr[g] = '0;
            mrr[g] = '0;
        end
        always @(posedge clk) begin
            if (mdld[g]) mdr[g] <= md_in;
            if (mrld[g]) mrr[g] <= mr_in;
            if (rsclear[g]) sum[g] <= '0;
            else if (rsload[g]) sum[g][8:4] <= {1'b0, sum[g][7:4]} + {1'b0, mdr[g]};
            else if (rsshr[g]) sum[g] <= sum[g] >> 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // {mdld, mrld, rsclear, rsload, rsshr, busy, done, bitidx[1:0]}
    function automatic logic [8:0] obs(input int k);
        return {mdld[k], mrld[k], rsclear[k], rsload[k], rsshr[k], busy[k], done[k], bidx[k]};
    endfunction

    // one full operation; poke[c] drives start during busy cycle c
    task automatic run_op(input int k, input logic [3:0] md, input logic [3:0] mr, input logic [15:0] poke,
                          output int busy_n, output int adds, output logic [7:0] prod);
        logic [8:0] q[$];
        logic [8:0] o;
        q.push_back({7'b1110010, 2'd0});
        for (int i = 0; i < 4; i++) begin
            if (i == 0 || k == 0 || mr[i]) q.push_back({3'b000, mr[i], 3'b010, 2'(i)});
            q.push_back({7'b0000110, 2'(i)});
        end
        q.push_back({7'b0000011, 2'd3});
        busy_n = 0;
        adds = 0;
        @(negedge clk);
        md_in = md;
        mr_in = mr;
        start[k] = 1'b1;
        for (int c = 1; c <= q.size() + 1; c++) begin
            @(negedge clk);
            o = obs(k);
            busy_n += int'(o[3]);
            adds += int'(o[5]);
            chk($sformatf("excl u%0d cyc%0d", k, c), {31'd0, o[5] & o[4]}, 32'd0);
            if (c <= q.size()) chk($sformatf("vec u%0d cyc%0d", k, c), {23'd0, o}, {23'd0, q[c-1]});
            else chk($sformatf("idle u%0d", k), {23'd0, o[8:2]}, 32'd0);
            start[k] = (c < 16) ? poke[c] : 1'b0;
        end
        start[k] = 1'b0;
        prod = sum[k][7:0];
    endtask

    typedef struct {
        int         k;
        logic [3:0] md;
        logic [3:0] mr;
        logic [7:0] prod;
        int         busy_n;
        int         adds;
    } vec_t;

    initial begin
        vec_t       tbl [7];
        int         bn;
        int         an;
        logic [7:0] p;
        logic [3:0] md;
        logic [3:0] mr;
        int         k;
        start[0] = 1'b0;
        start[1] = 1'b0;
        tbl[0] = '{0, 4'd11, 4'd13, 8'h8F, 10, 3};
        tbl[1] = '{0, 4'd15, 4'd15, 8'hE1, 10, 4};
        tbl[2] = '{0, 4'd9,  4'd0,  8'h00, 10, 0};
        tbl[3] = '{0, 4'd15, 4'd1,  8'h0F, 10, 1};
        tbl[4] = '{1, 4'd5,  4'd8,  8'h28, 8,  1};
        tbl[5] = '{1, 4'd7,  4'd0,  8'h00, 7,  0};
        tbl[6] = '{1, 4'd11, 4'd13, 8'h8F, 9,  3};
        repeat (2) @(negedge clk);
        chk("reset u0", {23'd0, obs(0)}, 32'd0);
        chk("reset u1", {23'd0, obs(1)}, 32'd0);
        rst_n = 1'b1;
        foreach (tbl[i]) begin
            run_op(tbl[i].k, tbl[i].md, tbl[i].mr, 16'h0, bn, an, p);
            chk($sformatf("tbl%0d prod", i), {24'd0, p}, {24'd0, tbl[i].prod});
            chk($sformatf("tbl%0d busy", i), bn, tbl[i].busy_n);
            chk($sformatf("tbl%0d adds", i), an, tbl[i].adds);
        end
        // start pulses in cycles 3 and 10 must be ignored
        run_op(0, 4'd11, 4'd13, 16'h0408, bn, an, p);
        chk("busystart prod", {24'd0, p}, 32'h8F);
        chk("busystart busy", bn, 10);
        @(negedge clk);
        chk("busystart idle", {31'd0, busy[0]}, 32'd0);
        // reset during SHIFT of bit 2
        md_in = 4'd9;
        mr_in = 4'd11;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre-reset shift", {29'd0, rsshr[0], bidx[0]}, {29'd0, 1'b1, 2'd2});
        #2 rst_n = 1'b0;
        #1 chk("async reset", {23'd0, obs(0)}, 32'd0);
        @(negedge clk);
        chk("held reset", {23'd0, obs(0)}, 32'd0);
        rst_n = 1'b1;
        run_op(0, 4'd7, 4'd6, 16'h0, bn, an, p);
        chk("post-reset prod", {24'd0, p}, 32'h2A);
        chk("post-reset busy", bn, 10);
        // random operations with ignored start pokes inside the busy window
        for (int i = 0; i < 1000; i++) begin
            k = i % 2;
            md = 4'($urandom);
            mr = 4'($urandom);
            run_op(k, md, mr, 16'($urandom) & 16'h00FE, bn, an, p);
            chk($sformatf("rnd%0d prod", i), {24'd0, p}, {24'd0, 8'(md * mr)});
            chk($sformatf("rnd%0d busy", i), bn, (k == 1) ? 7 + $countones(mr[3:1]) : 10);
            chk($sformatf("rnd%0d adds", i), an, $countones(mr));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
